// File: rtl/alu_cmd_ctrl_if.sv
// alu_cmd_ctrl_if: byte-stream, ALU and transmit signals of the ALU command sequencer
interface alu_cmd_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]   RX_P_DATA;
  logic                    RX_D_VLD;
  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    ALU_OUT_VLD;
  logic                    TX_BUSY;
  logic [DATA_WIDTH-1:0]   OP_A;
  logic [DATA_WIDTH-1:0]   OP_B;
  logic [3:0]              ALU_FUN;
  logic                    ALU_EN;
  logic                    CLK_GATE_EN;
  logic [DATA_WIDTH-1:0]   TX_P_DATA;
  logic                    TX_D_VLD;
  logic                    BUSY;
  logic                    ERR;
  modport master (
    input  RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
    output OP_A, OP_B, ALU_FUN, ALU_EN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD, BUSY, ERR
  );
  modport slave (
    output RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
    input  OP_A, OP_B, ALU_FUN, ALU_EN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD, BUSY, ERR
  );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: assembles ALU commands from received bytes, runs the ALU with a watchdog and returns the result as two bytes
module alu_cmd_ctrl #(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_OP  = 'hCC,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP = 'hDD,
  parameter int                    ALU_TIMEOUT = 15
) (
  input logic            CLK,
  input logic            RST,
  alu_cmd_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, GET_A, GET_B, GET_FUN, ALU_RUN, TX_LO, TX_HI} state_e;
  localparam logic [7:0] LIMIT = 8'(ALU_TIMEOUT - 1);
  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0]   op_b_q, op_b_d;
  logic [3:0]              fun_q, fun_d;
  logic [2*DATA_WIDTH-1:0] res_q, res_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_vld_q, tx_vld_d;
  logic                    alu_en_q, alu_en_d;
  logic                    gate_q, gate_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;
  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    fun_d     = fun_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    tx_vld_d  = tx_vld_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: if (bus.RX_D_VLD)
        state_d = (bus.RX_P_DATA == CMD_ALU_OP)  ? GET_A :
                  (bus.RX_P_DATA == CMD_ALU_NOP) ? GET_FUN : IDLE;
      GET_A: if (bus.RX_D_VLD) begin
        op_a_d  = bus.RX_P_DATA;
        state_d = GET_B;
      end
      GET_B: if (bus.RX_D_VLD) begin
        op_b_d  = bus.RX_P_DATA;
        state_d = GET_FUN;
      end
      GET_FUN: if (bus.RX_D_VLD) begin
        fun_d   = bus.RX_P_DATA[3:0];
        cnt_d   = '0;
        state_d = ALU_RUN;
      end
      ALU_RUN: begin
        cnt_d = cnt_q + 8'd1;
        if (bus.ALU_OUT_VLD) begin
          res_d     = bus.ALU_OUT;
          tx_data_d = bus.ALU_OUT[DATA_WIDTH-1:0];
          tx_vld_d  = 1'b1;
          state_d   = TX_LO;
        end else if (cnt_q == LIMIT) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      TX_LO: if (!bus.TX_BUSY) begin
        tx_data_d = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
        state_d   = TX_HI;
      end
      TX_HI: if (!bus.TX_BUSY) begin
        tx_vld_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    alu_en_d = (state_q != ALU_RUN) && (state_d == ALU_RUN);
    gate_d   = state_d == ALU_RUN;
    busy_d   = state_d != IDLE;
  end
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      op_a_q    <= '0;
      op_b_q    <= '0;
      fun_q     <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      alu_en_q  <= 1'b0;
      gate_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      fun_q     <= fun_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      alu_en_q  <= alu_en_d;
      gate_q    <= gate_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end
  assign bus.OP_A        = op_a_q;
  assign bus.OP_B        = op_b_q;
  assign bus.ALU_FUN     = fun_q;
  assign bus.ALU_EN      = alu_en_q;
  assign bus.CLK_GATE_EN = gate_q;
  assign bus.TX_P_DATA   = tx_data_q;
  assign bus.TX_D_VLD    = tx_vld_q;
  assign bus.BUSY        = busy_q;
  assign bus.ERR         = err_q;
endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb_alu_cmd_ctrl: directed and randomized command sequences checked against a transaction-level model
module tb_alu_cmd_ctrl;
  localparam int T = 15;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] m_a = '0, m_b = '0;
  logic [3:0] m_fun = '0;
  alu_cmd_ctrl_if #(.DATA_WIDTH(8)) bus ();
  alu_cmd_ctrl #(.DATA_WIDTH(8), .CMD_ALU_OP(8'hCC), .CMD_ALU_NOP(8'hDD), .ALU_TIMEOUT(T)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    step();
    bus.RX_D_VLD  = 1'b0;
  endtask
  task automatic jstep(input bit junk);
    bus.RX_D_VLD  = junk && ($urandom_range(1) == 1);
    bus.RX_P_DATA = 8'($urandom);
    step();
    bus.RX_D_VLD  = 1'b0;
  endtask
  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    case (f)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      4'd3:    return (b != 0) ? 16'(a / b) : 16'h0;
      4'd4:    return 16'(a & b);
      4'd5:    return 16'(a | b);
      4'd6:    return 16'(a ^ b);
      default: return {a, b} ^ 16'(f);
    endcase
  endfunction
  task automatic chk_regs(input string tag);
    chk({tag, "_op_a"}, bus.OP_A, m_a);
    chk({tag, "_op_b"}, bus.OP_B, m_b);
    chk({tag, "_fun"}, bus.ALU_FUN, m_fun);
  endtask
  task automatic chk_reset_outputs();
    chk("rst_op_a", bus.OP_A, 0);
    chk("rst_op_b", bus.OP_B, 0);
    chk("rst_fun", bus.ALU_FUN, 0);
    chk("rst_txd", bus.TX_P_DATA, 0);
    chk("rst_en", bus.ALU_EN, 0);
    chk("rst_gate", bus.CLK_GATE_EN, 0);
    chk("rst_txv", bus.TX_D_VLD, 0);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_err", bus.ERR, 0);
  endtask
  // lat >= T means the ALU never answers; abort resets the block while the high byte is pending
  task automatic do_op(input bit is_op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] f,
                       input int lat, input logic [15:0] res, input int blo, input int bhi,
                       input bit junk, input bit abort);
    if (is_op) begin
      send(8'hCC);
      chk("busy_cmd", bus.BUSY, 1);
      send(a);
      m_a = a;
      chk("op_a", bus.OP_A, m_a);
      send(b);
      m_b = b;
      chk("op_b", bus.OP_B, m_b);
    end else begin
      send(8'hDD);
      chk("busy_nop", bus.BUSY, 1);
    end
    send(f);
    m_fun = f[3:0];
    chk_regs("start");
    chk("alu_en", bus.ALU_EN, 1);
    chk("gate_start", bus.CLK_GATE_EN, 1);
    if (lat >= T) begin
      for (int i = 1; i < T; i++) begin
        jstep(junk);
        chk("to_en_pulse", bus.ALU_EN, 0);
        chk("to_err_early", bus.ERR, 0);
        chk("to_busy", bus.BUSY, 1);
      end
      jstep(junk);
      chk("to_err", bus.ERR, 1);
      chk("to_no_tx", bus.TX_D_VLD, 0);
      step();
      chk("to_err_pulse", bus.ERR, 0);
      chk("to_idle", bus.BUSY, 0);
      chk("to_no_tx_after", bus.TX_D_VLD, 0);
      chk_regs("to_end");
      return;
    end
    for (int i = 0; i < lat; i++) begin
      jstep(junk);
      chk("run_en_pulse", bus.ALU_EN, 0);
      chk("run_gate", bus.CLK_GATE_EN, 1);
      chk("run_err", bus.ERR, 0);
      chk("run_no_tx", bus.TX_D_VLD, 0);
    end
    bus.ALU_OUT_VLD = 1'b1;
    bus.ALU_OUT     = res;
    jstep(junk);
    bus.ALU_OUT_VLD = 1'b0;
    bus.ALU_OUT     = 16'($urandom);
    chk("tx_err", bus.ERR, 0);
    chk("tx_gate_off", bus.CLK_GATE_EN, 0);
    for (int i = 0; i <= blo; i++) begin
      chk("tx_lo_vld", bus.TX_D_VLD, 1);
      chk("tx_lo_data", bus.TX_P_DATA, res[7:0]);
      bus.TX_BUSY = (i < blo);
      jstep(junk);
    end
    for (int i = 0; i <= bhi; i++) begin
      chk("tx_hi_vld", bus.TX_D_VLD, 1);
      chk("tx_hi_data", bus.TX_P_DATA, res[15:8]);
      if (abort) begin
        bus.TX_BUSY = 1'b1;
        rst = 1'b0;
        step();
        chk_reset_outputs();
        rst = 1'b1;
        bus.TX_BUSY = 1'b0;
        m_a = '0;
        m_b = '0;
        m_fun = '0;
        step();
        chk("abort_idle", bus.BUSY, 0);
        chk("abort_no_tx", bus.TX_D_VLD, 0);
        return;
      end
      bus.TX_BUSY = (i < bhi);
      jstep(junk);
    end
    bus.TX_BUSY = 1'b0;
    chk("done_idle", bus.BUSY, 0);
    chk("done_no_tx", bus.TX_D_VLD, 0);
    chk("done_err", bus.ERR, 0);
    chk_regs("done");
  endtask
  initial begin
    logic [7:0] ra, rb, rf, ua, ub;
    bit is_op;
    int lat;
    bus.RX_P_DATA   = '0;
    bus.RX_D_VLD    = 1'b0;
    bus.ALU_OUT     = '0;
    bus.ALU_OUT_VLD = 1'b0;
    bus.TX_BUSY     = 1'b0;
    step();
    step();
    chk_reset_outputs();
    rst = 1'b1;
    step();
    do_op(1, 8'h05, 8'h03, 8'h00, 3, 16'h0008, 0, 0, 0, 0);
    do_op(0, 8'h00, 8'h00, 8'h0A, 2, alu_ref(m_a, m_b, 4'hA), 0, 0, 0, 0);
    do_op(1, 8'($urandom), 8'($urandom), 8'($urandom), 1, 16'h1234, 5, 0, 0, 0);
    do_op(1, 8'($urandom), 8'($urandom), 8'h02, T, 16'h0, 0, 0, 0, 0);
    do_op(0, 8'h00, 8'h00, 8'hF1, T - 1, alu_ref(m_a, m_b, 4'h1), 0, 0, 0, 0);
    send(8'h55);
    chk("junk_idle_busy", bus.BUSY, 0);
    chk_regs("junk_idle");
    bus.ALU_OUT_VLD = 1'b1;
    bus.ALU_OUT     = 16'hBEEF;
    step();
    bus.ALU_OUT_VLD = 1'b0;
    chk("stray_vld_busy", bus.BUSY, 0);
    chk("stray_vld_tx", bus.TX_D_VLD, 0);
    do_op(1, 8'h3C, 8'h11, 8'h05, 4, alu_ref(8'h3C, 8'h11, 4'h5), 2, 2, 1, 0);
    for (int i = 0; i < 24; i++) begin
      ra    = 8'($urandom);
      rb    = 8'($urandom);
      rf    = 8'($urandom);
      is_op = $urandom_range(1) == 1;
      lat   = $urandom_range(0, T);
      ua    = is_op ? ra : m_a;
      ub    = is_op ? rb : m_b;
      do_op(is_op, ra, rb, rf, lat, alu_ref(ua, ub, rf[3:0]),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1) == 1, 0);
    end
    do_op(1, 8'hA5, 8'h5A, 8'h06, 1, alu_ref(8'hA5, 8'h5A, 4'h6), 1, 2, 0, 1);
    do_op(0, 8'h00, 8'h00, 8'h00, 0, alu_ref(m_a, m_b, 4'h0), 0, 1, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_cmd_ctrl.md
# alu_cmd_ctrl

Command sequencer directly upstream of the ALU function decoder and ALU. It assembles ALU commands from the received byte stream: command, operands and a 4-bit function code. It drives `ALU_FUN`, the operands and the enable/clock-gate controls, then captures the 16-bit ALU result and returns it as two bytes over a valid/ready transmit interface. A watchdog aborts the operation if the ALU never reports a valid result.

## Interface
- `DATA_WIDTH`, 8: byte width of the RX/TX data and of each operand.
- `CMD_ALU_OP`, 8'hCC: command byte for an ALU operation with new operands.
- `CMD_ALU_NOP`, 8'hDD: command byte for an ALU operation that reuses the stored operands.
- `ALU_TIMEOUT`, 15: maximum number of cycles in `ALU_RUN` without `ALU_OUT_VLD`; range 1..255.

- `CLK`  in  1  single clock; all logic rises on posedge.
- `RST`  in  1  synchronous, active-low reset.
- `RX_P_DATA`  in  DATA_WIDTH  received byte.
- `RX_D_VLD`  in  1  one-cycle strobe; `RX_P_DATA` is valid in that cycle.
- `ALU_OUT`  in  2*DATA_WIDTH  ALU result.
- `ALU_OUT_VLD`  in  1  `ALU_OUT` is valid this cycle.
- `TX_BUSY`  in  1  transmitter busy; ready = !TX_BUSY.
- `OP_A`, `OP_B`  out  DATA_WIDTH  registered operands.
- `ALU_FUN`  out  4  registered function code fed to the decoder.
- `ALU_EN`  out  1  one-cycle start pulse.
- `CLK_GATE_EN`  out  1  ALU clock-gate enable.
- `TX_P_DATA`  out  DATA_WIDTH  result byte.
- `TX_D_VLD`  out  1  result byte valid.
- `BUSY`  out  1  high in every state except IDLE.
- `ERR`  out  1  one-cycle pulse on timeout.

## Operation
- Registered FSM with states IDLE, GET_A, GET_B, GET_FUN, ALU_RUN, TX_LO, TX_HI.
- **IDLE**
  - `RX_D_VLD` with `CMD_ALU_OP` → GET_A.
  - `RX_D_VLD` with `CMD_ALU_NOP` → GET_FUN; `OP_A`/`OP_B` keep their last values.
  - Any other byte is ignored.
- **GET_A / GET_B / GET_FUN:** each waits for `RX_D_VLD`, then latches `RX_P_DATA` into `OP_A`, `OP_B` or `ALU_FUN` (`RX_P_DATA[3:0]`; upper bits are discarded) and advances. No timeout applies while waiting for bytes.
- **ALU_RUN**
  - `ALU_EN` is high only in the first cycle; `CLK_GATE_EN` is high for the whole state.
  - An 8-bit counter clears on entry and increments every cycle.
  - `ALU_OUT_VLD` → capture `ALU_OUT` into the result register, go to TX_LO.
  - Counter reaches `ALU_TIMEOUT` with no `ALU_OUT_VLD` → pulse `ERR`, go to IDLE, transmit nothing.
  - `ALU_OUT_VLD` in the same cycle as the counter reaching the limit: the valid result wins and no `ERR` is raised.
- **TX_LO / TX_HI**
  - `TX_D_VLD` = 1 and `TX_P_DATA` = `result[7:0]`, then `result[15:8]`.
  - Both are held stable until an accept cycle (`TX_D_VLD` & !`TX_BUSY`).
  - Accept in TX_LO → TX_HI; accept in TX_HI → IDLE.
  - Low byte is always sent first.
- `RX_D_VLD` in ALU_RUN, TX_LO or TX_HI is dropped and never queued.
- `ALU_OUT_VLD` outside ALU_RUN is ignored.
- Reset (`RST`=0) in any state, including mid-transmit, returns the FSM to IDLE on that edge. The partially sent result is discarded.

## Timing
- Reset values:
  - `OP_A`, `OP_B`, `ALU_FUN`, `TX_P_DATA`, result register, counter = 0.
  - `ALU_EN`, `CLK_GATE_EN`, `TX_D_VLD`, `BUSY`, `ERR` = 0.
- Function byte strobed in cycle N → `ALU_FUN` updated and `ALU_EN`=1 in N+1.
- `ALU_OUT_VLD` in cycle M → `TX_D_VLD`=1 with the low byte in M+1.
- `TX_BUSY` low throughout → low byte accepted at M+1, high byte presented and accepted at M+2, `BUSY`=0 from M+3.
- Timeout: `ALU_EN` in cycle K, no valid result → `ERR`=1 in cycle K+`ALU_TIMEOUT`, IDLE from the next cycle.
- `BUSY` is 0 only in IDLE, with reset included.
- All outputs are registered.

## Test plan
- **Full op.**
  - Stimulus: RX CC, 05, 03, 00; ALU returns 0x0008 three cycles after `ALU_EN`; `TX_BUSY`=0.
  - Required: `OP_A`=05, `OP_B`=03, `ALU_FUN`=0, a single `ALU_EN` pulse, TX bytes 08 then 00 on consecutive cycles, then IDLE.
- **NOP reuse.**
  - Stimulus: after the full op, RX DD, 0A.
  - Required: `OP_A`/`OP_B` stay 05/03, `ALU_FUN`=0xA, one new `ALU_EN`.
- **TX backpressure.**
  - Stimulus: `TX_BUSY`=1 for 5 cycles after the result 0x1234.
  - Required: `TX_P_DATA`=34 with `TX_D_VLD` held all 5 cycles, accepted on the first not-busy cycle, then 12.
- **Timeout.**
  - Stimulus: `ALU_OUT_VLD` never asserts.
  - Required: `ERR` pulses exactly `ALU_TIMEOUT` cycles after `ALU_EN`, no `TX_D_VLD`, IDLE afterwards.
  - Also: `ALU_OUT_VLD` on the limit cycle → the result is sent and no `ERR`.
- **Junk and overlap.**
  - Stimulus: RX 55 in IDLE, then RX bytes during ALU_RUN and TX.
  - Required: none of these bytes change state or registers.
- **Reset mid-TX.**
  - Stimulus: `RST`=0 during TX_HI.
  - Required: next cycle all outputs are at reset values and the FSM is in IDLE.
